mmio_io_responder: RTL and testbench

MMIO_IO_RESPONDER -- requirements
Module: mmio_io_responder

---
 rtl/mmio_io_responder.sv | 172 +++++++++++++++++
 tb/tb_mmio_io_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_responder.sv
// MMIO slave for board I/O: LEDs, 7-seg digit values, debounced keys with edge capture,
// synchronized switches and a free-running cycle counter. One access per req/ack handshake.
module mmio_io_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        ack,
    output logic [31:0] rdata,
    input  logic [3:0]  key_n,
    input  logic [9:0]  sw,
    output logic [9:0]  ledr,
    output logic [23:0] hex
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [9:0]      leds_q, leds_d;
    logic [23:0]     hex_q, hex_d;
    logic [31:0]     cycles_q, cycles_d;
    logic [3:0]      key_s1_q, key_s2_q;
    logic [9:0]      sw_s1_q, sw_s2_q;
    logic [3:0]      level_q, level_d;
    logic [3:0]      cap_q, cap_d;
    logic [CntW-1:0] cnt_q [4];
    logic [CntW-1:0] cnt_d [4];

    logic        accept;
    logic [5:0]  sel;
    logic        onehot;
    logic        wr_leds, wr_hex, wr_key, wr_cycles;
    logic [31:0] bmask;
    logic [31:0] cycles_inc;
    logic [31:0] leds_merge, hex_merge;
    logic [3:0]  pressed, rise, clr;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign unused_addr = ^{addr[31:8], addr[1:0]};

    // Bus decode: only addr[7:2] matters, and exactly one bit must be set to hit a register
    assign accept = (state_q == IDLE) && req;
    assign sel    = addr[7:2];
    assign onehot = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    assign wr_leds   = accept && we && onehot && sel[0];
    assign wr_hex    = accept && we && onehot && sel[1];
    assign wr_key    = accept && we && onehot && sel[2];
    assign wr_cycles = accept && we && onehot && sel[4];
    assign bmask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

    assign cycles_inc = cycles_q + 32'd1;
    assign leds_merge = ({22'd0, leds_q} & ~bmask) | (wdata & bmask);
    assign hex_merge  = ({8'd0, hex_q} & ~bmask) | (wdata & bmask);

    // Handshake FSM: a request taken in IDLE is answered in the following RESP cycle
    always_comb begin
        state_d = IDLE;
        if (accept) begin
            state_d = RESP;
        end
    end

    // Register write paths; CYCLES counts every cycle but enabled write lanes override
    always_comb begin
        leds_d   = leds_q;
        hex_d    = hex_q;
        cycles_d = cycles_inc;
        if (wr_leds) begin
            leds_d = leds_merge[9:0];
        end
        if (wr_hex) begin
            hex_d = hex_merge[23:0];
        end
        if (wr_cycles) begin
            cycles_d = (cycles_inc & ~bmask) | (wdata & bmask);
        end
    end

    // Per-key debounce: level follows pressed only after DEBOUNCE_CYCLES differing samples
    always_comb begin
        pressed = ~key_s2_q;
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (pressed[i] != level_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    level_d[i] = pressed[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Edge capture with W1C; a new press edge beats a clear in the same cycle
    always_comb begin
        rise  = level_d & ~level_q;
        clr   = (wr_key && wmask[0]) ? wdata[7:4] : 4'd0;
        cap_d = (cap_q & ~clr) | rise;
    end

    // Read mux; unmapped addresses read as zero
    always_comb begin
        rd_val = '0;
        if (onehot) begin
            if (sel[0]) begin
                rd_val = {22'd0, leds_q};
            end else if (sel[1]) begin
                rd_val = {8'd0, hex_q};
            end else if (sel[2]) begin
                rd_val = {24'd0, cap_q, level_q};
            end else if (sel[3]) begin
                rd_val = {22'd0, sw_s2_q};
            end else if (sel[4]) begin
                rd_val = cycles_q;
            end
        end
        rdata_d = (accept && !we) ? rd_val : rdata_q;
    end

    // State update; synchronous active-low reset clears everything, key syncs idle high
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            leds_q   <= '0;
            hex_q    <= '0;
            cycles_q <= '0;
            key_s1_q <= 4'hF;
            key_s2_q <= 4'hF;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            level_q  <= '0;
            cap_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            leds_q   <= leds_d;
            hex_q    <= hex_d;
            cycles_q <= cycles_d;
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            level_q  <= level_d;
            cap_q    <= cap_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ack   = (state_q == RESP);
    assign rdata = rdata_q;
    assign ledr  = leds_q;
    assign hex   = hex_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Bench for mmio_io_responder: read expectations go through a scoreboard queue and are
// compared when ack appears; register outputs are checked directly.
module tb_mmio_io_responder;

    localparam int unsigned DebounceCycles = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        ack;
    logic [31:0] rdata;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [23:0] hex;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    mmio_io_responder #(
        .DEBOUNCE_CYCLES(DebounceCycles)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .wmask   (wmask),
        .ack     (ack),
        .rdata   (rdata),
        .key_n   (key_n),
        .sw      (sw),
        .ledr    (ledr),
        .hex     (hex)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access starting at a negedge in IDLE; returns at the negedge of the next IDLE cycle
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] exp, input string tag);
        int n;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        wmask = m;
        if (!w) exp_q.push_back(exp);
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (!ack && n < 4);
        check_eq({tag, "_lat"}, n, 1);
        if (!w) begin
            if (ack) check_eq(tag, rdata, exp_q.pop_front());
            else void'(exp_q.pop_front());
        end
        req = 1'b0;
        we  = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus(1'b1, a, d, m, 32'd0, "wr");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus(1'b0, a, 32'd0, 4'h0, exp, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        wmask = '0;
        key_n = 4'hF;
        sw    = '0;
        repeat (3) @(negedge CLOCK_50);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_ledr", ledr, 0);
        check_eq("rst_hex", hex, 0);

        // first edge out of reset accepts the access; counter still zero there
        reset = 1'b1;
        rd(32'h140, 32'd0, "cyc_first");

        // LEDS
        wr(32'h104, 32'h3FF, 4'hF);
        check_eq("ledr_full", ledr, 32'h3FF);
        rd(32'h104, 32'h3FF, "leds_rd");
        wr(32'h104, 32'h0001_2155, 4'h1);
        check_eq("ledr_lane0", ledr, 32'h355);
        wr(32'h104, 32'h0, 4'h0);
        check_eq("ledr_nomask", ledr, 32'h355);

        // HEX
        wr(32'h108, 32'h00AB_CDEF, 4'h2);
        check_eq("hex_lane1", hex, 32'h00CD00);
        wr(32'h108, 32'h00AB_CDEF, 4'hF);
        check_eq("hex_full", hex, 32'hABCDEF);
        rd(32'h108, 32'h00AB_CDEF, "hex_rd");

        // unmapped and aliased addresses
        wr(32'h10C, 32'h0, 4'hF);
        check_eq("unmap_ledr", ledr, 32'h355);
        check_eq("unmap_hex", hex, 32'hABCDEF);
        rd(32'h10C, 32'd0, "rd_10c");
        rd(32'h100, 32'd0, "rd_100");
        rd(32'h180, 32'd0, "rd_180");
        rd(32'h1104, 32'h355, "rd_alias");

        // SW via synchronizer, read-only
        sw = 10'h2A5;
        repeat (3) @(negedge CLOCK_50);
        rd(32'h120, 32'h2A5, "sw_rd");
        wr(32'h120, 32'h0, 4'hF);
        rd(32'h120, 32'h2A5, "sw_ro");

        // req held high: accepted every other cycle
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h104;
        exp_q.push_back(32'h355);
        exp_q.push_back(32'h355);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge CLOCK_50);
            check_eq("b2b_ack", ack, (i % 2));
            if (ack && exp_q.size() > 0) check_eq("b2b_rdata", rdata, exp_q.pop_front());
        end
        req = 1'b0;
        @(negedge CLOCK_50);

        // CYCLES wrap: write, 2 idle cycles, read -> three increments after the write edge
        wr(32'h140, 32'hFFFF_FFFE, 4'hF);
        repeat (2) @(negedge CLOCK_50);
        rd(32'h140, 32'hFFFF_FFFE + 32'd3, "cyc_wrap");
        // counter was 3 at the write edge: upper lanes take 4, lane 0 takes 0x78; +1 before read
        wr(32'h140, 32'h1234_5678, 4'h1);
        rd(32'h140, 32'h0000_0079, "cyc_lane0");

        // key0 glitches shorter than the debounce interval never register
        for (int g = 0; g < 4; g++) begin
            key_n = 4'b1110;
            repeat (2) @(negedge CLOCK_50);
            key_n = 4'b1111;
            repeat (3) @(negedge CLOCK_50);
        end
        rd(32'h110, 32'h00, "key_glitch");

        // key1 press, capture, W1C
        key_n = 4'b1101;
        repeat (10) @(negedge CLOCK_50);
        rd(32'h110, 32'h22, "key1_press");
        wr(32'h110, 32'h20, 4'h1);
        rd(32'h110, 32'h02, "key1_w1c");
        key_n = 4'b1111;
        repeat (2) @(negedge CLOCK_50);
        key_n = 4'b1101;
        repeat (10) @(negedge CLOCK_50);
        rd(32'h110, 32'h02, "key1_glitch");
        key_n = 4'b1111;
        repeat (10) @(negedge CLOCK_50);
        rd(32'h110, 32'h00, "key1_release");

        // key0: clear needs wmask[0]; wdata[3:0] ignored
        key_n = 4'b1110;
        repeat (10) @(negedge CLOCK_50);
        rd(32'h110, 32'h11, "key0_press");
        wr(32'h110, 32'h10, 4'h2);
        rd(32'h110, 32'h11, "key0_nomask");
        wr(32'h110, 32'h1F, 4'h1);
        rd(32'h110, 32'h01, "key0_w1c");

        // key2: clear on the very edge the debounced level rises -> capture stays set
        key_n = 4'b1010;
        repeat (10) @(negedge CLOCK_50);
        rd(32'h110, 32'h45, "key2_press");
        key_n = 4'b1110;
        repeat (10) @(negedge CLOCK_50);
        rd(32'h110, 32'h41, "key2_release");
        key_n = 4'b1010;
        repeat (5) @(negedge CLOCK_50);
        wr(32'h110, 32'h40, 4'h1);
        rd(32'h110, 32'h45, "key2_clr_vs_edge");

        // reset during RESP of a LEDS write
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h104;
        wdata = 32'h2AA;
        wmask = 4'hF;
        @(negedge CLOCK_50);
        check_eq("abort_ack_resp", ack, 1);
        reset = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        @(negedge CLOCK_50);
        check_eq("abort_ack", ack, 0);
        check_eq("abort_ledr", ledr, 0);
        check_eq("abort_hex", hex, 0);
        reset = 1'b1;
        rd(32'h104, 32'd0, "abort_leds_rd");
        rd(32'h110, 32'd0, "abort_key_rd");
        key_n = 4'hF;

        check_eq("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
